sext_pipe: RTL

//  Parametrised, pipelined successor of the single-cycle immediate extender in the cpu_SoC decode path.

---
 rtl/sext_pipe_if.sv | 30 +++
 rtl/sext_pipe.sv | 109 ++++++++++
 2 files changed

// File: rtl/sext_pipe_if.sv
// Handshake bundle for the pipelined immediate extender.
//   master: the producer/consumer side (ID stage feeding in, ID/EX register taking out)
//   slave : the extender itself
// Input beat : in_valid/in_ready, sext_op, imm (inst[31:7]), in_tag
// Output beat: out_valid/out_ready, imm_sext, out_tag, illegal
interface sext_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       sext_op;
  logic [24:0]      imm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_sext;
  logic [TAG_W-1:0] out_tag;
  logic             illegal;

  modport master (
    output in_valid, sext_op, imm, in_tag, out_ready,
    input  in_ready, out_valid, imm_sext, out_tag, illegal
  );

  modport slave (
    input  in_valid, sext_op, imm, in_tag, out_ready,
    output in_ready, out_valid, imm_sext, out_tag, illegal
  );
endinterface

// File: rtl/sext_pipe.sv
// Pipelined immediate extender for the decode path.
// Extends the 25-bit immediate field (inst[31:7]) per a 3-bit format select to
// XLEN bits, then carries {value, tag, illegal} through DEPTH register stages
// with a valid/ready handshake. Latency = DEPTH, capacity = DEPTH beats.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears valid and data registers
//   flush : synchronous kill of every in-flight beat (and of a beat offered this cycle)
//   bus   : sext_pipe_if.slave handshake bundle (input beat / output beat)
module sext_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1,
  parameter int TAG_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  sext_pipe_if.slave  bus
);

  generate
    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
      $error("sext_pipe: XLEN must be 32 or 64");
    end
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("sext_pipe: DEPTH must be 1..4");
    end
  endgenerate

  localparam int LAST = DEPTH - 1;

  typedef struct packed {
    logic [XLEN-1:0]  val;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } beat_t;

  // Combinational extension, always formed at 64 bits and truncated to XLEN.
  logic [63:0] ext_w;
  logic        ext_ill;
  logic [24:0] f;
  beat_t       ext;

  assign f = bus.imm;

  always_comb begin
    ext_w   = '0;
    ext_ill = 1'b0;
    case (bus.sext_op)
      3'b001: ext_w = {{52{f[24]}}, f[24:13]};
      3'b011: begin
        if (XLEN == 32) begin
          // RV32 shamt is 5 bits; bit 5 set is an illegal encoding.
          ext_w   = {59'd0, f[17:13]};
          ext_ill = f[18];
        end else begin
          ext_w   = {58'd0, f[18:13]};
        end
      end
      3'b000: ext_w = {{52{f[24]}}, f[24:18], f[4:0]};
      3'b010: ext_w = {{51{f[24]}}, f[24], f[0], f[23:18], f[4:1], 1'b0};
      3'b100: ext_w = {{32{f[24]}}, f[24:5], 12'd0};
      3'b110: ext_w = {{43{f[24]}}, f[24], f[12:5], f[13], f[23:14], 1'b0};
      3'b101: ext_w = {59'd0, f[12:8]};
      default: ext_ill = 1'b1;
    endcase
  end

  assign ext.val = ext_w[XLEN-1:0];
  assign ext.tag = bus.in_tag;
  assign ext.ill = ext_ill;

  logic  [LAST:0] vld_pipe;
  beat_t          pipe [DEPTH];
  logic  [LAST:0] load;

  // Stage i can load unless it and every stage after it are full while the
  // consumer stalls. Closed form avoids a bit-to-bit combinational chain.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_load
      assign load[gi] = ~(&vld_pipe[LAST:gi]) | bus.out_ready;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else if (flush) begin
      // Kill everything in flight; data registers keep their old contents.
      vld_pipe <= '0;
    end else begin
      if (load[0]) vld_pipe[0] <= bus.in_valid;
      if (load[0] && bus.in_valid) pipe[0] <= ext;
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i]) vld_pipe[i] <= vld_pipe[i-1];
        if (load[i] && vld_pipe[i-1]) pipe[i] <= pipe[i-1];
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = vld_pipe[LAST];
  assign bus.imm_sext  = pipe[LAST].val;
  assign bus.out_tag   = pipe[LAST].tag;
  assign bus.illegal   = pipe[LAST].ill;

endmodule
